// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback controller.
package wb_pkg;

  localparam int unsigned XLEN_C = 32;
  localparam int unsigned NREG_C = 32;

  typedef struct packed {
    logic [4:0]        rd;
    logic [XLEN_C-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  function automatic logic [NREG_C-1:0] rd_onehot(input logic [4:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback FIFO; exposes per-entry valid/rd so the top can build
// the pending-destination mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               din,
  output logic                  full,
  input  logic                  pop,
  output logic                  empty,
  output wb_req_t               head,
  output logic [DEPTH-1:0]      ent_valid,
  output logic [DEPTH-1:0][4:0] ent_rd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [DEPTH-1:0] vld;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  // push and pop never hit the same slot: pop implies non-empty, push implies non-full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (push) begin
        vld[wptr] <= 1'b1;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        vld[rptr] <= 1'b0;
        rptr      <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head      = mem[rptr];
  assign ent_valid = vld;

  always_comb begin
    ent_rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-side controller: two buffered writeback sources,
// round-robin arbitration, registered write port and pending-destination mask.
// Optional feature: WB_BYPASS_EN (empty-FIFO live input may go straight to the write port).
module regfile_wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            rf_write,
  output logic [4:0]      rf_write_reg,
  output logic [XLEN-1:0] rf_write_data,
  output logic [31:0]     pending_mask
);

  wb_req_t alu_req, lsu_req;
  wb_req_t alu_head, lsu_head;
  wb_req_t alu_cur, lsu_cur, sel;

  logic alu_full, alu_empty, alu_push, alu_pop, alu_cand;
  logic lsu_full, lsu_empty, lsu_push, lsu_pop, lsu_cand;
  logic gnt_alu, gnt_lsu;

  logic [DEPTH-1:0]      alu_ev, lsu_ev;
  logic [DEPTH-1:0][4:0] alu_er, lsu_er;

  wb_src_e last_grant;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign lsu_req = '{rd: lsu_rd, data: lsu_data};

  assign alu_ready = rst_n && !alu_full;
  assign lsu_ready = rst_n && !lsu_full;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .din       (alu_req),
    .full      (alu_full),
    .pop       (alu_pop),
    .empty     (alu_empty),
    .head      (alu_head),
    .ent_valid (alu_ev),
    .ent_rd    (alu_er)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsu_push),
    .din       (lsu_req),
    .full      (lsu_full),
    .pop       (lsu_pop),
    .empty     (lsu_empty),
    .head      (lsu_head),
    .ent_valid (lsu_ev),
    .ent_rd    (lsu_er)
  );

`ifdef WB_BYPASS_EN
  // An empty FIFO offers its live input; if granted it skips the FIFO entirely.
  assign alu_cand = !alu_empty || alu_valid;
  assign lsu_cand = !lsu_empty || lsu_valid;
  assign alu_cur  = alu_empty ? alu_req : alu_head;
  assign lsu_cur  = lsu_empty ? lsu_req : lsu_head;
  assign alu_push = alu_valid && alu_ready && !(gnt_alu && alu_empty);
  assign lsu_push = lsu_valid && lsu_ready && !(gnt_lsu && lsu_empty);
  assign alu_pop  = gnt_alu && !alu_empty;
  assign lsu_pop  = gnt_lsu && !lsu_empty;
`else
  assign alu_cand = !alu_empty;
  assign lsu_cand = !lsu_empty;
  assign alu_cur  = alu_head;
  assign lsu_cur  = lsu_head;
  assign alu_push = alu_valid && alu_ready;
  assign lsu_push = lsu_valid && lsu_ready;
  assign alu_pop  = gnt_alu;
  assign lsu_pop  = gnt_lsu;
`endif

  assign gnt_alu = alu_cand && (!lsu_cand || (last_grant == SRC_LSU));
  assign gnt_lsu = lsu_cand && !gnt_alu;
  assign sel     = gnt_alu ? alu_cur : lsu_cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_write      <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      last_grant    <= SRC_LSU;
    end else if (gnt_alu || gnt_lsu) begin
      rf_write      <= (sel.rd != 5'd0);
      rf_write_reg  <= sel.rd;
      rf_write_data <= sel.data;
      last_grant    <= gnt_alu ? SRC_ALU : SRC_LSU;
    end else begin
      rf_write      <= 1'b0;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alu_ev[i]) pending_mask = pending_mask | rd_onehot(alu_er[i]);
      if (lsu_ev[i]) pending_mask = pending_mask | rd_onehot(lsu_er[i]);
    end
    if (rf_write) pending_mask = pending_mask | rd_onehot(rf_write_reg);
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl (default build, DEPTH=2).
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] pending_mask;

  int ncmp  = 0;
  int nfail = 0;

  regfile_wb_ctrl #(.XLEN(32), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .pending_mask  (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      $error("%s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int ai, li, wi, first, last;
    logic acc_a, acc_l;
    logic [4:0] erd;

    idle();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_write",     32'(rf_write), 32'd0);
    chk("rst_reg",       32'(rf_write_reg), 32'd0);
    chk("rst_data",      rf_write_data, 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("rst_mask",      pending_mask, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
    chk("post_rst_lsu_ready", 32'(lsu_ready), 32'd1);

    // Test 1: single ALU write, 2-edge latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    idle();
    chk("t1_e1_write", 32'(rf_write), 32'd0);
    chk("t1_e1_mask",  pending_mask, 32'h0000_0020);
    step();
    chk("t1_e2_write", 32'(rf_write), 32'd1);
    chk("t1_e2_reg",   32'(rf_write_reg), 32'd5);
    chk("t1_e2_data",  rf_write_data, 32'hDEADBEEF);
    chk("t1_e2_mask",  pending_mask, 32'h0000_0020);
    step();
    chk("t1_e3_write", 32'(rf_write), 32'd0);
    chk("t1_e3_reg",   32'(rf_write_reg), 32'd5);
    chk("t1_e3_mask",  pending_mask, 32'd0);

    // Test 2: simultaneous pushes after reset, ALU wins the tie
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    step();
    idle();
    chk("t2_mask", pending_mask, 32'h0000_0006);
    step();
    chk("t2_w1_write", 32'(rf_write), 32'd1);
    chk("t2_w1_reg",   32'(rf_write_reg), 32'd1);
    chk("t2_w1_data",  rf_write_data, 32'h11);
    step();
    chk("t2_w2_write", 32'(rf_write), 32'd1);
    chk("t2_w2_reg",   32'(rf_write_reg), 32'd2);
    chk("t2_w2_data",  rf_write_data, 32'h22);
    step();
    chk("t2_idle_write", 32'(rf_write), 32'd0);

    // Test 3: both sources saturated, strict alternation ALU,LSU,...
    ai = 0; li = 0; wi = 0; first = -1; last = -1;
    for (int c = 0; c < 40 && wi < 16; c++) begin
      alu_valid = (ai < 8); alu_rd = 5'(8 + ai);  alu_data = 32'hA000_0000 | 32'(8 + ai);
      lsu_valid = (li < 8); lsu_rd = 5'(16 + li); lsu_data = 32'hB000_0000 | 32'(16 + li);
      acc_a = alu_valid && alu_ready;
      acc_l = lsu_valid && lsu_ready;
      step();
      if (acc_a) ai++;
      if (acc_l) li++;
      if (rf_write) begin
        erd = (wi % 2 == 0) ? 5'(8 + wi / 2) : 5'(16 + wi / 2);
        chk("t3_reg",  32'(rf_write_reg), 32'(erd));
        chk("t3_data", rf_write_data, ((wi % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(erd));
        if (first < 0) first = c;
        last = c;
        wi++;
      end
    end
    idle();
    chk("t3_count", 32'(wi), 32'd16);
    chk("t3_span",  32'(last - first), 32'd15);
    step();
    chk("t3_drained_mask", pending_mask, 32'd0);

    // Test 4: LSU FIFO fills under contention; mask tracks every buffered rd
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    step();
    chk("t4_e1_mask", pending_mask, 32'h0000_0018);
    alu_rd = 5'd6; alu_data = 32'h66;
    lsu_rd = 5'd7; lsu_data = 32'h77;
    step();
    idle();
    chk("t4_e2_reg",       32'(rf_write_reg), 32'd3);
    chk("t4_e2_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("t4_e2_alu_ready", 32'(alu_ready), 32'd1);
    chk("t4_e2_mask",      pending_mask, 32'h0000_00D8);
    step();
    chk("t4_e3_reg",  32'(rf_write_reg), 32'd4);
    chk("t4_e3_mask", pending_mask, 32'h0000_00D0);
    step();
    chk("t4_e4_reg",  32'(rf_write_reg), 32'd6);
    chk("t4_e4_mask", pending_mask, 32'h0000_00C0);
    step();
    chk("t4_e5_reg",  32'(rf_write_reg), 32'd7);
    chk("t4_e5_mask", pending_mask, 32'h0000_0080);
    step();
    chk("t4_e6_write", 32'(rf_write), 32'd0);
    chk("t4_e6_mask",  pending_mask, 32'd0);

    // Test 5: rd=0 is consumed without a write
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    step();
    alu_rd = 5'd9; alu_data = 32'h99;
    chk("t5_e1_mask", pending_mask, 32'd0);
    step();
    idle();
    chk("t5_e2_write", 32'(rf_write), 32'd0);
    chk("t5_e2_data",  rf_write_data, 32'hFFFFFFFF);
    chk("t5_e2_mask",  pending_mask, 32'h0000_0200);
    step();
    chk("t5_e3_write", 32'(rf_write), 32'd1);
    chk("t5_e3_reg",   32'(rf_write_reg), 32'd9);
    step();
    chk("t5_e4_write", 32'(rf_write), 32'd0);

    // Test 6: reset while loaded discards everything
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC;
    step();
    alu_rd = 5'd11; alu_data = 32'hB;
    lsu_rd = 5'd13; lsu_data = 32'hD;
    step();
    idle();
    chk("t6_reg",       32'(rf_write_reg), 32'd12);
    chk("t6_alu_ready", 32'(alu_ready), 32'd0);
    chk("t6_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("t6_mask",      pending_mask, 32'h0000_3C00);
    rst_n = 1'b0;
    step();
    chk("t6_rst_write",     32'(rf_write), 32'd0);
    chk("t6_rst_mask",      pending_mask, 32'd0);
    chk("t6_rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("t6_rst_lsu_ready", 32'(lsu_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t6_post_alu_ready", 32'(alu_ready), 32'd1);
    chk("t6_post_lsu_ready", 32'(lsu_ready), 32'd1);
    step();
    chk("t6_p1_write", 32'(rf_write), 32'd0);
    chk("t6_p1_mask",  pending_mask, 32'd0);
    step();
    chk("t6_p2_write", 32'(rf_write), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
